// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline stall/flush sequencer.
package pipeline_hazard_ctrl_pkg;

    localparam int REGFILE_BITS  = 5;
    localparam int HZ_STATE_BITS = 2;

    typedef enum logic [HZ_STATE_BITS-1:0] {
        HZ_RUN      = 2'd0,
        HZ_DIV_WAIT = 2'd1,
        HZ_DC_WAIT  = 2'd2
    } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-source / stall-flush bundle between the pipeline (master) and the sequencer (slave).
// Perf counter signals exist only when HAZARD_PERF_CNT_EN is defined.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_BITS = 5,
    parameter int CNT_W    = 32
);
    logic [REG_BITS-1:0] id_rs1;
    logic [REG_BITS-1:0] id_rs2;
    logic                id_use_rs1;
    logic                id_use_rs2;
    logic [REG_BITS-1:0] exe_rd;
    logic                exe_is_load;
    logic                exe_div_start;
    logic                div_done;
    logic                mem_dc_miss;
    logic                dc_ready;
    logic                exe_redirect;

    logic stall_if;
    logic stall_id;
    logic stall_exe;
    logic flush_id;
    logic flush_exe;
    logic flush_mem;
    logic flush_wb;
    logic busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] perf_lu_cnt;
    logic [CNT_W-1:0] perf_div_cnt;
    logic [CNT_W-1:0] perf_dc_cnt;
    logic [CNT_W-1:0] perf_flush_cnt;
`endif

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, exe_rd, exe_is_load,
               exe_div_start, div_done, mem_dc_miss, dc_ready, exe_redirect,
`ifdef HAZARD_PERF_CNT_EN
        input  perf_lu_cnt, perf_div_cnt, perf_dc_cnt, perf_flush_cnt,
`endif
        input  stall_if, stall_id, stall_exe, flush_id, flush_exe, flush_mem,
               flush_wb, busy
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, exe_rd, exe_is_load,
               exe_div_start, div_done, mem_dc_miss, dc_ready, exe_redirect,
`ifdef HAZARD_PERF_CNT_EN
        output perf_lu_cnt, perf_div_cnt, perf_dc_cnt, perf_flush_cnt,
`endif
        output stall_if, stall_id, stall_exe, flush_id, flush_exe, flush_mem,
               flush_wb, busy
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_lu_detect.sv
// Combinational load-use comparator; also usable by the forwarding unit.
module hazard_lu_detect #(
    parameter int REG_BITS = 5
) (
    input  logic [REG_BITS-1:0] id_rs1_i,
    input  logic [REG_BITS-1:0] id_rs2_i,
    input  logic                id_use_rs1_i,
    input  logic                id_use_rs2_i,
    input  logic [REG_BITS-1:0] exe_rd_i,
    input  logic                exe_is_load_i,
    output logic                lu_hit_o
);
    logic rs1_hit;
    logic rs2_hit;

    // x0 is hard-wired zero, so a load targeting it never creates a dependency
    assign rs1_hit  = id_use_rs1_i && (id_rs1_i == exe_rd_i);
    assign rs2_hit  = id_use_rs2_i && (id_rs2_i == exe_rd_i);
    assign lu_hit_o = exe_is_load_i && (exe_rd_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer: owns the core's only wait-state FSM (RUN/DIV_WAIT/DC_WAIT).
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_BITS    = REGFILE_BITS,
    parameter int DIV_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  nrst,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int TW = (DIV_TIMEOUT > 2) ? $clog2(DIV_TIMEOUT) : 1;

    hz_state_e         state_q, state_d;
    logic [TW-1:0]     div_cnt_q, div_cnt_d;
    logic              lu_hit;
    logic              div_exit;
    logic              lu_fire;
    logic              redir_fire;

    hazard_lu_detect #(.REG_BITS(REG_BITS)) u_lu (
        .id_rs1_i      (hz.id_rs1),
        .id_rs2_i      (hz.id_rs2),
        .id_use_rs1_i  (hz.id_use_rs1),
        .id_use_rs2_i  (hz.id_use_rs2),
        .exe_rd_i      (hz.exe_rd),
        .exe_is_load_i (hz.exe_is_load),
        .lu_hit_o      (lu_hit)
    );

    assign div_exit = hz.div_done || (div_cnt_q == TW'(DIV_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= HZ_RUN;
            div_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_cnt_d = '0;
        case (state_q)
            HZ_RUN: begin
                if (hz.mem_dc_miss)        state_d = HZ_DC_WAIT;
                else if (hz.exe_div_start) state_d = HZ_DIV_WAIT;
            end
            HZ_DC_WAIT: begin
                if (hz.dc_ready) state_d = HZ_RUN;
            end
            HZ_DIV_WAIT: begin
                div_cnt_d = div_cnt_q + 1'b1;
                if (div_exit) state_d = HZ_RUN;
            end
            default: state_d = HZ_RUN;
        endcase
    end

    // Everything is gated by nrst so a held reset never leaks a stall or flush.
    always_comb begin
        hz.stall_if  = 1'b0;
        hz.stall_id  = 1'b0;
        hz.stall_exe = 1'b0;
        hz.flush_id  = 1'b0;
        hz.flush_exe = 1'b0;
        hz.flush_mem = 1'b0;
        hz.flush_wb  = 1'b0;
        hz.busy      = 1'b0;
        lu_fire      = 1'b0;
        redir_fire   = 1'b0;
        if (nrst) begin
            hz.busy = (state_q != HZ_RUN);
            case (state_q)
                HZ_RUN: begin
                    if (hz.mem_dc_miss) begin
                        hz.stall_if  = 1'b1;
                        hz.stall_id  = 1'b1;
                        hz.stall_exe = 1'b1;
                        hz.flush_wb  = 1'b1;
                    end else if (hz.exe_div_start) begin
                        hz.stall_if  = 1'b1;
                        hz.stall_id  = 1'b1;
                        hz.flush_mem = 1'b1;
                    end else if (hz.exe_redirect) begin
                        hz.flush_id  = 1'b1;
                        hz.flush_exe = 1'b1;
                        redir_fire   = 1'b1;
                    end else if (lu_hit) begin
                        hz.stall_if  = 1'b1;
                        hz.flush_exe = 1'b1;
                        lu_fire      = 1'b1;
                    end
                end
                HZ_DC_WAIT: begin
                    hz.stall_if  = 1'b1;
                    hz.stall_id  = 1'b1;
                    hz.stall_exe = 1'b1;
                    hz.flush_wb  = 1'b1;
                end
                HZ_DIV_WAIT: begin
                    hz.stall_if  = 1'b1;
                    hz.stall_id  = 1'b1;
                    // Dropping the bubble lets EXE/MEM capture the divider result
                    hz.flush_mem = !div_exit;
                end
                default: ;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] lu_cnt_q, div_cnt_perf_q, dc_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            lu_cnt_q       <= '0;
            div_cnt_perf_q <= '0;
            dc_cnt_q       <= '0;
            flush_cnt_q    <= '0;
        end else begin
            if (lu_fire && !(&lu_cnt_q))
                lu_cnt_q <= lu_cnt_q + 1'b1;
            if (state_q == HZ_DIV_WAIT && !(&div_cnt_perf_q))
                div_cnt_perf_q <= div_cnt_perf_q + 1'b1;
            if (state_q == HZ_DC_WAIT && !(&dc_cnt_q))
                dc_cnt_q <= dc_cnt_q + 1'b1;
            if (redir_fire && !(&flush_cnt_q))
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign hz.perf_lu_cnt    = lu_cnt_q;
    assign hz.perf_div_cnt   = div_cnt_perf_q;
    assign hz.perf_dc_cnt    = dc_cnt_q;
    assign hz.perf_flush_cnt = flush_cnt_q;
`else
    logic unused_fire;
    assign unused_fire = lu_fire ^ redir_fire;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; second instance uses DIV_TIMEOUT=8 for the timeout path.
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_BITS(5), .CNT_W(32)) hz ();
    pipeline_hazard_ctrl_if #(.REG_BITS(5), .CNT_W(32)) hz2 ();

    pipeline_hazard_ctrl #(.REG_BITS(5), .DIV_TIMEOUT(64), .CNT_W(32)) dut (
        .clk(clk), .nrst(nrst), .hz(hz));
    pipeline_hazard_ctrl #(.REG_BITS(5), .DIV_TIMEOUT(8), .CNT_W(32)) dut_to (
        .clk(clk), .nrst(nrst), .hz(hz2));

    // {stall_if, stall_id, stall_exe, flush_id, flush_exe, flush_mem, flush_wb, busy}
    function automatic logic [7:0] obs_a();
        return {hz.stall_if, hz.stall_id, hz.stall_exe, hz.flush_id,
                hz.flush_exe, hz.flush_mem, hz.flush_wb, hz.busy};
    endfunction

    function automatic logic [7:0] obs_b();
        return {hz2.stall_if, hz2.stall_id, hz2.stall_exe, hz2.flush_id,
                hz2.flush_exe, hz2.flush_mem, hz2.flush_wb, hz2.busy};
    endfunction

    task automatic idle_inputs();
        hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_use_rs1 = 0; hz.id_use_rs2 = 0;
        hz.exe_rd = '0; hz.exe_is_load = 0; hz.exe_div_start = 0; hz.div_done = 0;
        hz.mem_dc_miss = 0; hz.dc_ready = 0; hz.exe_redirect = 0;
        hz2.id_rs1 = '0; hz2.id_rs2 = '0; hz2.id_use_rs1 = 0; hz2.id_use_rs2 = 0;
        hz2.exe_rd = '0; hz2.exe_is_load = 0; hz2.exe_div_start = 0; hz2.div_done = 0;
        hz2.mem_dc_miss = 0; hz2.dc_ready = 0; hz2.exe_redirect = 0;
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled mid-cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] o;
        nrst = 1'b0;
        idle_inputs();
        hz.mem_dc_miss = 1'b1;
        hz.exe_redirect = 1'b1;
        next_cycle();
        next_cycle();
        #3;
        o = obs_a();
        total++;
        if (o !== 8'b0000_0000) begin
            $display("FAIL reset_forced_zero got=%b want=%b", o, 8'b0);
            bad++;
        end
        idle_inputs();
        nrst = 1'b1;
        next_cycle();
        #3;
        o = obs_a();
        total++;
        if (o !== 8'b0000_0000) begin
            $display("FAIL reset_idle got=%b want=%b", o, 8'b0);
            bad++;
        end
`ifdef HAZARD_PERF_CNT_EN
        total++;
        if ({hz.perf_lu_cnt, hz.perf_div_cnt, hz.perf_dc_cnt, hz.perf_flush_cnt} !== 128'd0) begin
            $display("FAIL reset_perf got=%0d/%0d/%0d/%0d want=0", hz.perf_lu_cnt,
                     hz.perf_div_cnt, hz.perf_dc_cnt, hz.perf_flush_cnt);
            bad++;
        end
`endif
    endtask

    task automatic test_load_use();
        logic [7:0] o;
        // rs1 match, rd=0, rs2 match, match but unused
        logic [4:0] rd_v  [4] = '{5'd5, 5'd0, 5'd7, 5'd9};
        logic [4:0] rs1_v [4] = '{5'd5, 5'd0, 5'd1, 5'd9};
        logic [4:0] rs2_v [4] = '{5'd2, 5'd0, 5'd7, 5'd9};
        logic       u1_v  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic       u2_v  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0] exp_v [4] = '{8'b1000_1000, 8'b0, 8'b1000_1000, 8'b0};
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            hz.exe_is_load = 1'b1;
            hz.exe_rd = rd_v[i];
            hz.id_rs1 = rs1_v[i];
            hz.id_rs2 = rs2_v[i];
            hz.id_use_rs1 = u1_v[i];
            hz.id_use_rs2 = u2_v[i];
            #3;
            o = obs_a();
            total++;
            if (o !== exp_v[i]) begin
                $display("FAIL load_use[%0d] got=%b want=%b", i, o, exp_v[i]);
                bad++;
            end
            next_cycle();
            idle_inputs();
            #3;
            o = obs_a();
            total++;
            if (o !== 8'b0) begin
                $display("FAIL load_use_after[%0d] got=%b want=%b", i, o, 8'b0);
                bad++;
            end
            next_cycle();
        end
    endtask

    task automatic test_redirect_lu();
        logic [7:0] o;
        idle_inputs();
        hz.exe_is_load = 1'b1;
        hz.exe_rd = 5'd5;
        hz.id_rs1 = 5'd5;
        hz.id_use_rs1 = 1'b1;
        hz.exe_redirect = 1'b1;
        #3;
        o = obs_a();
        total++;
        if (o !== 8'b0001_1000) begin
            $display("FAIL redirect_lu got=%b want=%b", o, 8'b0001_1000);
            bad++;
        end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_divide();
        logic [7:0] o;
        logic [7:0] e;
        idle_inputs();
        hz.exe_div_start = 1'b1;
        for (int c = 0; c <= 34; c++) begin
            hz.div_done = (c == 33);
            hz.exe_div_start = (c <= 33);
            // a stray miss while MEM holds a bubble must be ignored
            hz.mem_dc_miss = (c == 10);
            if (c == 0)       e = 8'b1100_0100;
            else if (c < 33)  e = 8'b1100_0101;
            else if (c == 33) e = 8'b1100_0001;
            else              e = 8'b0000_0000;
            #3;
            o = obs_a();
            total++;
            if (o !== e) begin
                $display("FAIL divide cyc=%0d got=%b want=%b", c, o, e);
                bad++;
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_cache_miss();
        logic [7:0] o;
        logic [7:0] e;
        idle_inputs();
        for (int c = 0; c <= 12; c++) begin
            hz.mem_dc_miss = (c <= 10);
            hz.dc_ready = (c == 10);
            hz.exe_redirect = (c >= 5 && c <= 11);
            if (c <= 10)      e = (c == 0) ? 8'b1110_0010 : 8'b1110_0011;
            else if (c == 11) e = 8'b0001_1000;
            else              e = 8'b0000_0000;
            #3;
            o = obs_a();
            total++;
            if (o !== e) begin
                $display("FAIL cache_miss cyc=%0d got=%b want=%b", c, o, e);
                bad++;
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_div_timeout();
        logic [7:0] o;
        logic [7:0] e;
        idle_inputs();
        for (int c = 0; c <= 9; c++) begin
            hz2.exe_div_start = (c <= 8);
            if (c == 0)      e = 8'b1100_0100;
            else if (c < 8)  e = 8'b1100_0101;
            else if (c == 8) e = 8'b1100_0001;
            else             e = 8'b0000_0000;
            #3;
            o = obs_b();
            total++;
            if (o !== e) begin
                $display("FAIL div_timeout cyc=%0d got=%b want=%b", c, o, e);
                bad++;
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_wait();
        logic [7:0] o;
        idle_inputs();
        hz.mem_dc_miss = 1'b1;
        next_cycle();
        next_cycle();
        #3;
        o = obs_a();
        total++;
        if (o !== 8'b1110_0011) begin
            $display("FAIL mid_wait_pre got=%b want=%b", o, 8'b1110_0011);
            bad++;
        end
        hz.mem_dc_miss = 1'b0;
        nrst = 1'b0;
        #1;
        o = obs_a();
        total++;
        if (o !== 8'b0) begin
            $display("FAIL mid_wait_in_reset got=%b want=%b", o, 8'b0);
            bad++;
        end
        next_cycle();
        nrst = 1'b1;
        #3;
        o = obs_a();
        total++;
        if (o !== 8'b0) begin
            $display("FAIL mid_wait_after got=%b want=%b", o, 8'b0);
            bad++;
        end
`ifdef HAZARD_PERF_CNT_EN
        total++;
        if ({hz.perf_lu_cnt, hz.perf_div_cnt, hz.perf_dc_cnt, hz.perf_flush_cnt} !== 128'd0) begin
            $display("FAIL mid_wait_perf got=%0d/%0d/%0d/%0d want=0", hz.perf_lu_cnt,
                     hz.perf_div_cnt, hz.perf_dc_cnt, hz.perf_flush_cnt);
            bad++;
        end
`endif
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_redirect_lu();
        test_divide();
        test_cache_miss();
        test_div_timeout();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32IMC pipeline.
- Inputs: hazard sources (load-use, multi-cycle divider, data-cache miss, branch/jump redirect).
- Outputs: per-stage stall (hold) and flush (bubble) controls for the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers.
- Owns the only wait-state FSM in the core, so pipeline registers stay plain hold/clear registers.

Parameters:
- REG_BITS, 5: register index width.
- DIV_TIMEOUT, 64: max cycles in DIV_WAIT before forced exit; must be ≥ divider latency + 2.
- CNT_W, 32: width of performance counters (optional feature only).

Ports:
- clk  in  1  clock
- nrst  in  1  synchronous active-low reset
- id_rs1  in  REG_BITS  ID-stage source 1 index
- id_rs2  in  REG_BITS  ID-stage source 2 index
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- exe_rd  in  REG_BITS  EXE-stage destination
- exe_is_load  in  1  EXE instruction is a load
- exe_div_start  in  1  EXE holds a DIV/REM, divider starting
- div_done  in  1  divider result valid (1-cycle pulse)
- mem_dc_miss  in  1  MEM-stage access missed the data cache
- dc_ready  in  1  cache refill/writeback complete (1-cycle pulse)
- exe_redirect  in  1  EXE-stage taken branch/jump, PC redirected
- stall_if  out  1  hold PC and IF/ID
- stall_id  out  1  hold ID/EXE
- stall_exe  out  1  hold EXE/MEM
- flush_id  out  1  clear IF/ID
- flush_exe  out  1  clear ID/EXE
- flush_mem  out  1  clear EXE/MEM
- flush_wb  out  1  clear MEM/WB
- busy  out  1  FSM not in RUN

Behaviour:
- Reset:
  - nrst sampled on posedge clk; state ← RUN; DIV_WAIT timeout counter ← 0.
  - All outputs are combinational from state and inputs, but forced to 0 while nrst=0.
  - Reset mid-wait drops to RUN on the next edge with no residual stall.
- States (2-bit, registered): RUN=0, DIV_WAIT=1, DC_WAIT=2.
- RUN, evaluated in priority order; first match wins:
  1. mem_dc_miss: stall_if, stall_id, stall_exe, flush_wb = 1; next state DC_WAIT.
  2. exe_div_start: stall_if, stall_id = 1; flush_mem = 1; next state DIV_WAIT; counter ← 0.
  3. exe_redirect: flush_id, flush_exe = 1; no stalls; stay RUN. A load-use condition in the same cycle is ignored, because the ID instruction is flushed.
  4. Load-use: exe_is_load && exe_rd≠0 && ((id_use_rs1 && id_rs1==exe_rd) || (id_use_rs2 && id_rs2==exe_rd)). Outputs stall_if=1, flush_exe=1 for exactly one cycle; stay RUN.
  5. Otherwise: all outputs 0.
- DC_WAIT:
  - stall_if, stall_id, stall_exe, flush_wb = 1 every cycle.
  - On dc_ready: same outputs that cycle; next state RUN.
  - EXE-stage redirect/div requests are frozen and re-evaluated in RUN on the following cycle.
- DIV_WAIT:
  - stall_if, stall_id, flush_mem = 1 every cycle; counter increments.
  - On div_done: stall_if and stall_id remain 1; flush_mem = 0, so the result is captured into EXE/MEM. Next state RUN.
  - Counter reaching DIV_TIMEOUT−1 without div_done: same outputs as div_done; next state RUN (fail-safe).
  - mem_dc_miss cannot occur, because MEM holds a bubble; it is ignored if asserted.
- exe_div_start is expected to drop the cycle after the divider result is captured. Re-entry requires a fresh assertion observed in RUN.
- busy = (state≠RUN).

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_lu_cnt, perf_div_cnt, perf_dc_cnt, perf_flush_cnt, each CNT_W wide.
  - They count load-use bubble cycles, DIV_WAIT cycles, DC_WAIT cycles, and redirect flushes respectively.
  - All counters are cleared by nrst and saturate at all-ones.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- constants.vh gains HZ_RUN, HZ_DIV_WAIT, HZ_DC_WAIT state encodings and HZ_STATE_BITS=2; reuses REGFILE_BITS for REG_BITS.
- One natural sub-module: hazard_lu_detect, the combinational load-use comparator, reusable by the forwarding unit.
- FSM, counter and output decode stay in the top module.

Test Plan:
- Load-use: exe_is_load=1, exe_rd=5, id_use_rs1=1, id_rs1=5 for one cycle → stall_if=1, flush_exe=1 that cycle only. With exe_rd=0, both outputs remain 0.
- Redirect + load-use in the same cycle, exe_redirect=1 → flush_id=1, flush_exe=1, stall_if=0.
- Divide: exe_div_start=1, div_done pulsed 33 cycles later → busy=1 for 33 cycles and flush_mem=1 for 32 of them. On the div_done cycle, flush_mem=0 and stall_if=1; the next cycle is RUN with all outputs 0.
- Cache miss: mem_dc_miss=1, dc_ready after 10 cycles → stall_if, stall_id, stall_exe, flush_wb all 1 for 11 cycles, then 0. A pending exe_redirect flushes on the first RUN cycle.
- Divide timeout: DIV_TIMEOUT=8, no div_done → exit to RUN after 8 DIV_WAIT cycles.
- Reset mid-DC_WAIT: nrst=0 for one edge → all outputs 0, busy=0 next cycle. With HAZARD_PERF_CNT_EN defined, all counters read 0.
